// File: rtl/cpu_run_ctrl_if.sv
// rtl/cpu_run_ctrl_if.sv - host command handshake bundle for cpu_run_ctrl
interface cpu_run_ctrl_if;
  logic       cmd_valid;
  logic [1:0] cmd_op;
  logic       cmd_ready;

  modport master (output cmd_valid, output cmd_op, input cmd_ready);
  modport slave  (input cmd_valid, input cmd_op, output cmd_ready);
endinterface

// File: rtl/cpu_run_ctrl.sv
// rtl/cpu_run_ctrl.sv - run/step/halt/preset sequencer for the single-cycle core (optional CPU_RUN_CTRL_BREAKPOINT_EN)
module cpu_run_ctrl #(
  parameter int CNT_W         = 32,
  parameter int PRESET_CYCLES = 4
) (
  input  logic              clk_in,
  input  logic              rst,
  cpu_run_ctrl_if.slave     cmd,
  input  logic              hlt_in,
  input  logic [31:0]       pc,
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  input  logic              bp_valid,
  input  logic [31:0]       bp_addr,
  output logic              bp_hit,
`endif
  output logic              cpu_en,
  output logic              cpu_preset,
  output logic [2:0]        run_state,
  output logic              step_done,
  output logic              halted_evt,
  output logic [CNT_W-1:0]  cycle_count
);

  typedef enum logic [2:0] {
    S_PAUSE  = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_HALTED = 3'd3,
    S_PRESET = 3'd4
  } state_t;

  localparam logic [1:0] OP_STOP   = 2'b00;
  localparam logic [1:0] OP_RUN    = 2'b01;
  localparam logic [1:0] OP_STEP   = 2'b10;
  localparam logic [1:0] OP_PRESET = 2'b11;

  localparam logic [7:0] PRESET_LAST = 8'(PRESET_CYCLES - 1);

  state_t           state_q;
  logic             cpu_preset_q;
  logic             step_done_q;
  logic             halted_evt_q;
  logic [7:0]       preset_cnt_q;
  logic [CNT_W-1:0] cycle_count_q;
  logic [CNT_W-1:0] cycle_count_d;
  logic             cmd_ready_w;
  logic             cmd_acc;
  logic             bp_match;

`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
  logic first_run_q;
  logic bp_hit_q;

  // Breakpoint compare is skipped on the first RUN cycle so a RUN issued while parked on it advances.
  always_comb begin
    bp_match = (state_q == S_RUN) & ~first_run_q & bp_valid & (pc == bp_addr) & ~hlt_in;
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign bp_match  = 1'b0;
`endif

  // Commands are only taken in states that can react to them on the next edge.
  always_comb begin
    cmd_ready_w = (state_q == S_PAUSE) | (state_q == S_RUN) | (state_q == S_HALTED);
    cmd_acc     = cmd.cmd_valid & cmd_ready_w;
    cpu_en      = ((state_q == S_RUN) | (state_q == S_STEP)) & ~hlt_in & ~bp_match;
  end

  // Saturating executed-cycle counter next value.
  always_comb begin
    cycle_count_d = cycle_count_q;
    if (cpu_en && (cycle_count_q != {CNT_W{1'b1}})) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end
  end

  // Sequencer FSM with registered preset and event pulses; entering PRESET clears the counter.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q       <= S_PAUSE;
      cpu_preset_q  <= 1'b0;
      step_done_q   <= 1'b0;
      halted_evt_q  <= 1'b0;
      preset_cnt_q  <= 8'd0;
      cycle_count_q <= '0;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      first_run_q   <= 1'b0;
      bp_hit_q      <= 1'b0;
`endif
    end else begin
      step_done_q   <= 1'b0;
      halted_evt_q  <= 1'b0;
      cycle_count_q <= cycle_count_d;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
      bp_hit_q      <= 1'b0;
      first_run_q   <= 1'b0;
`endif
      case (state_q)
        S_PAUSE: begin
          if (cmd_acc) begin
            case (cmd.cmd_op)
              OP_RUN: begin
                state_q <= S_RUN;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
                first_run_q <= 1'b1;
`endif
              end
              OP_STEP: state_q <= S_STEP;
              OP_PRESET: begin
                state_q       <= S_PRESET;
                cpu_preset_q  <= 1'b1;
                preset_cnt_q  <= PRESET_LAST;
                cycle_count_q <= '0;
              end
              default: ;
            endcase
          end
        end
        S_RUN: begin
          if (hlt_in) begin
            state_q      <= S_HALTED;
            halted_evt_q <= 1'b1;
          end else if (bp_match) begin
            state_q <= S_PAUSE;
`ifdef CPU_RUN_CTRL_BREAKPOINT_EN
            bp_hit_q <= 1'b1;
`endif
          end else if (cmd_acc) begin
            if (cmd.cmd_op == OP_STOP) begin
              state_q <= S_PAUSE;
            end else if (cmd.cmd_op == OP_PRESET) begin
              state_q       <= S_PRESET;
              cpu_preset_q  <= 1'b1;
              preset_cnt_q  <= PRESET_LAST;
              cycle_count_q <= '0;
            end
          end
        end
        S_STEP: begin
          if (hlt_in) begin
            state_q      <= S_HALTED;
            halted_evt_q <= 1'b1;
          end else begin
            state_q     <= S_PAUSE;
            step_done_q <= 1'b1;
          end
        end
        S_HALTED: begin
          if (cmd_acc && (cmd.cmd_op == OP_PRESET)) begin
            state_q       <= S_PRESET;
            cpu_preset_q  <= 1'b1;
            preset_cnt_q  <= PRESET_LAST;
            cycle_count_q <= '0;
          end
        end
        S_PRESET: begin
          if (preset_cnt_q == 8'd0) begin
            state_q      <= S_PAUSE;
            cpu_preset_q <= 1'b0;
          end else begin
            preset_cnt_q <= preset_cnt_q - 8'd1;
          end
        end
        default: state_q <= S_PAUSE;
      endcase
    end
  end

  assign cmd.cmd_ready = cmd_ready_w;
  assign cpu_preset    = cpu_preset_q;
  assign run_state     = state_q;
  assign step_done     = step_done_q;
  assign halted_evt    = halted_evt_q;
  assign cycle_count   = cycle_count_q;

endmodule

// File: doc/cpu_run_ctrl.md
Name: cpu_run_ctrl

Overview:
Run/step/halt sequencer for the single-cycle RISC-V core. It sits between a debug/host command port and the datapath.
- Gates the datapath's clock enable.
- Drives the datapath preset.
- Reacts to the control unit's hlt.
- Counts executed cycles.
It lets a host start, stop, single-step and re-preset the core without touching the board reset.

Parameters:
CNT_W, 32, width of executed-cycle counter cycle_count
PRESET_CYCLES, 4, number of cycles cpu_preset is held high per PRESET command (legal range 1..255)

Ports:
clk_in  input  1  core clock (same clock as datapath clk_in)
rst  input  1  asynchronous, active-high reset
cmd_valid  input  1  host command valid
cmd_op  input  2  00 STOP, 01 RUN, 10 STEP, 11 PRESET
cmd_ready  output  1  command accepted when cmd_valid & cmd_ready
hlt_in  input  1  halt indication from control unit (current instruction is HLT)
pc  input  32  current PC from datapath
cpu_en  output  1  datapath write/PC-update enable (combinational)
cpu_preset  output  1  preset to datapath (registered)
run_state  output  3  0 PAUSE, 1 RUN, 2 STEP, 3 HALTED, 4 PRESET
step_done  output  1  one-cycle pulse after a STEP retires
halted_evt  output  1  one-cycle pulse on entry to HALTED
cycle_count  output  CNT_W  number of cycles with cpu_en=1, saturating

Behaviour:
- Reset (async, rst=1) values:
  - run_state=PAUSE, cpu_preset=0, step_done=0, halted_evt=0, cycle_count=0.
  - cpu_en=0 and cmd_ready=1, because both are derived from state.
- cpu_en = (run_state==RUN | run_state==STEP) & ~hlt_in. A HLT instruction never commits.
- cmd_ready=1 in PAUSE, RUN and HALTED; 0 in STEP and PRESET. An accepted command takes effect on the next clock edge.
- PAUSE:
  - RUN -> RUN.
  - STEP -> STEP.
  - PRESET -> PRESET.
  - STOP -> no-op.
- RUN:
  - hlt_in=1 -> HALTED. Takes priority over a simultaneous STOP or PRESET command, which is consumed and dropped.
  - Else STOP -> PAUSE; PRESET -> PRESET; RUN and STEP are accepted and ignored.
- STEP:
  - Lasts exactly 1 cycle.
  - If hlt_in=0: cpu_en=1, next state PAUSE, step_done=1 for the following cycle.
  - If hlt_in=1: next state HALTED, no step_done.
- HALTED:
  - cpu_en=0.
  - Only PRESET leaves it (-> PRESET); STOP, RUN and STEP are accepted and ignored.
  - halted_evt=1 for exactly the first cycle in HALTED.
- PRESET:
  - cpu_preset=1 for exactly PRESET_CYCLES consecutive cycles, starting the cycle after acceptance.
  - cycle_count is cleared to 0 on entry.
  - Then -> PAUSE with cpu_preset=0 in the same cycle.
- cycle_count:
  - Increments by 1 on each clock edge where cpu_en=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Reset asserted mid-STEP or mid-PRESET aborts immediately to reset values. No pulse outputs fire.
- pc is used only by the optional feature; otherwise unused.

Optional Feature:
Macro: CPU_RUN_CTRL_BREAKPOINT_EN.

When defined, the block gains these ports:
- bp_valid (input, 1)
- bp_addr (input, 32)
- bp_hit (output, 1): one-cycle pulse, reset value 0.

Breakpoint behaviour in RUN:
- Condition: bp_valid & (pc==bp_addr) & ~hlt_in.
- On a match: cpu_en is forced to 0 that cycle, the next state is PAUSE, and bp_hit=1 for the following cycle.
- The compare is suppressed on the first RUN cycle after entering RUN, so a RUN issued while parked on the breakpoint PC makes progress.
- STEP ignores breakpoints.
- hlt_in takes priority over a breakpoint.

When the macro is undefined: the ports are absent and the behaviour is exactly as above.

Test Plan:
- Reset, then RUN; hlt_in raised on cycle 10 of RUN -> cpu_en high for 10 cycles, cycle_count=10, run_state=HALTED, halted_evt single pulse, cpu_en=0 thereafter.
- From PAUSE issue STEP three times (hlt_in=0) -> cpu_en high for exactly 1 cycle each, three step_done pulses, cycle_count=3, run_state=PAUSE.
- HALTED, issue RUN then PRESET -> RUN ignored (state stays HALTED); PRESET gives cpu_preset high for exactly 4 cycles, cycle_count=0, then PAUSE.
- RUN with STOP and hlt_in asserted in the same cycle -> HALTED, not PAUSE; halted_evt=1.
- CNT_W=4, RUN for 20 cycles -> cycle_count saturates at 15.
- With CPU_RUN_CTRL_BREAKPOINT_EN, bp_addr=0x20, bp_valid=1, pc reaches 0x20 -> cpu_en=0 that cycle, bp_hit pulse, PAUSE. A following RUN advances past 0x20 without re-hitting; rst asserted mid-PRESET -> all outputs return to reset values immediately.
